// File: rtl/la_dsync_debounce_if.sv
// Level bundle between an asynchronous source and la_dsync_debounce.
// The source side (master) drives the raw levels; the filter side (slave)
// returns the synchronized, debounced levels and their edge pulses.
// There is no handshake: in is a free-running level and out/rise/fall are
// plain registered levels/pulses valid on every clk cycle.
interface la_dsync_debounce_if #(
  parameter int N = 1
);
  logic [N-1:0] in;
  logic [N-1:0] out;
  logic [N-1:0] rise;
  logic [N-1:0] fall;

  modport master (
    output in,
    input  out,
    input  rise,
    input  fall
  );

  modport slave (
    input  in,
    output out,
    output rise,
    output fall
  );
endinterface

// File: rtl/la_dsync_debounce.sv
// Multi-channel synchronizer + debounce filter + edge detect.
// Each channel runs a STAGES-deep flop chain into clk, then a stability
// counter that accepts a new level only after it has held for CYCLES clocks.
// Optional macro LA_DSYNC_DEBOUNCE_EDGE_EN enables the registered rise/fall
// pulses; without it rise/fall are constant 0 and no edge flops exist.
module la_dsync_debounce #(
  parameter        PROP   = "DEFAULT",
  parameter int    N      = 1,
  parameter int    STAGES = 2,
  parameter int    CYCLES = 4,
  parameter logic  INIT   = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  la_dsync_debounce_if.slave    io
);

  localparam int             CW      = $clog2(CYCLES + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(CYCLES - 1);

  // Synchronizer chain; index 0 is the first (metastable-prone) flop.
  logic [N-1:0]  sync_q [STAGES];
  logic [N-1:0]  sync_s;

  // Filter state.
  logic [N-1:0]  out_q;
  logic [N-1:0]  out_d;
  logic [CW-1:0] cnt_q [N];
  logic [CW-1:0] cnt_d [N];

  assign sync_s = sync_q[STAGES-1];

  // Shift the raw inputs through the synchronizer chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        sync_q[k] <= {N{INIT}};
      end
    end else begin
      sync_q[0] <= io.in;
      for (int k = 1; k < STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  // Per-channel stability count: any agreement with out restarts the count,
  // and the level is accepted on the CYCLES-th consecutive disagreement.
  // The counter never exceeds CYCLES-1, so it cannot wrap.
  always_comb begin
    out_d = out_q;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = '0;
      if (sync_s[i] != out_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          out_d[i] = sync_s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Register the filtered level and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= {N{INIT}};
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      out_q <= out_d;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign io.out = out_q;

`ifdef LA_DSYNC_DEBOUNCE_EDGE_EN
  logic [N-1:0] rise_q;
  logic [N-1:0] fall_q;

  // Edge pulses register together with out, so they line up with the cycle
  // in which out changes. Reset forces them low, so reset never pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= out_d & ~out_q;
      fall_q <= ~out_d & out_q;
    end
  end

  assign io.rise = rise_q;
  assign io.fall = fall_q;
`else
  assign io.rise = '0;
  assign io.fall = '0;
`endif

endmodule
